// File: rtl/rv32_muldiv_sequencer.sv
// Iterative RV32 M-extension unit: shift-add multiply, restoring divide,
// and the sequencer that stalls exec while an op is in flight.
module rv32_muldiv_sequencer #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  input  logic        hold,
  output logic        stall_req,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        busy
);

  localparam int unsigned STEPS = 32 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      acc, acc_step;
  logic [31:0]      opnd;
  logic [2:0]       op_q;
  logic             neg_lo, neg_hi;
  logic             rs1_signed, rs2_signed, neg1, neg2;
  logic [31:0]      mag1, mag2;
  logic             div_zero, div_ovf, special;
  logic [31:0]      special_val, fix_val;
  logic [63:0]      prod_fix;
  logic [31:0]      quo_fix, rem_fix;
  logic             accept, calc_en, fix_en;

  // One iteration: multiply keeps {partial sum, multiplier} in acc; divide keeps {remainder, quotient}.
  function automatic logic [63:0] mul_div_step(input logic [63:0] p, input logic [31:0] d,
                                               input logic is_div);
    logic [32:0] sum;
    logic [32:0] rr;
    if (!is_div) begin
      sum = {1'b0, p[63:32]} + (p[0] ? {1'b0, d} : 33'd0);
      mul_div_step = {sum, p[31:1]};
    end else begin
      rr = {p[63:32], p[31]};
      if (rr >= {1'b0, d}) mul_div_step = {32'(rr - {1'b0, d}), p[30:0], 1'b1};
      else                 mul_div_step = {rr[31:0], p[30:0], 1'b0};
    end
  endfunction

  // Operand magnitudes, signs and divide special cases
  always_comb begin
    rs1_signed  = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
    rs2_signed  = rs1_signed && (op != 3'd2);
    neg1        = rs1_signed & rs1[31];
    neg2        = rs2_signed & rs2[31];
    mag1        = neg1 ? -rs1 : rs1;
    mag2        = neg2 ? -rs2 : rs2;
    div_zero    = op[2] && (rs2 == 32'h0);
    div_ovf     = op[2] && !op[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    special     = div_zero | div_ovf;
    special_val = div_zero ? (op[1] ? rs1 : 32'hFFFF_FFFF)
                           : (op[1] ? 32'h0 : 32'h8000_0000);
  end

  always_comb begin
    acc_step = acc;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++)
      acc_step = mul_div_step(acc_step, opnd, op_q[2]);
  end

  // Sign correction and word select
  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    quo_fix  = neg_lo ? -acc[31:0] : acc[31:0];
    rem_fix  = neg_hi ? -acc[63:32] : acc[63:32];
    case (op_q)
      3'd0:                fix_val = prod_fix[31:0];
      3'd1, 3'd2, 3'd3:    fix_val = prod_fix[63:32];
      3'd4, 3'd5:          fix_val = quo_fix;
      default:             fix_val = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall_req    = 1'b0;
    result_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          stall_req = 1'b1;
          state_nxt = special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        stall_req = 1'b1;
        if (cnt == '0) state_nxt = S_FIXUP;
      end
      S_FIXUP: begin
        stall_req = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (!hold) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A squashed instruction wins over everything, including a fresh start
    if (flush) begin
      state_nxt    = S_IDLE;
      stall_req    = 1'b0;
      result_valid = 1'b0;
    end
    if (reset) stall_req = 1'b0;
  end

  assign accept  = (state == S_IDLE) && start && !flush;
  assign calc_en = (state == S_CALC) && !flush;
  assign fix_en  = (state == S_FIXUP) && !flush;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_q   <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op_q   <= op;
      opnd   <= op[2] ? mag2 : mag1;
      acc    <= op[2] ? {32'h0, mag1} : {32'h0, mag2};
      neg_lo <= neg1 ^ neg2;
      neg_hi <= neg1;
      cnt    <= CNT_LOAD;
      if (special) result <= special_val;
    end else if (calc_en) begin
      acc <= acc_step;
      cnt <= cnt - CNT_W'(1);
    end else if (fix_en) begin
      result <= fix_val;
    end
  end

endmodule

// File: tb/tb_rv32_muldiv_sequencer.sv
// Scoreboard bench for rv32_muldiv_sequencer: two instances (1 and 4 bits per cycle)
// checked against an arithmetic reference model, including latency and hold behaviour.
module tb_rv32_muldiv_sequencer;

  typedef struct {
    logic [31:0] value;
    int          stall;
    int          vlen;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s [2];
  logic [2:0]  op_s    [2];
  logic [31:0] rs1_s   [2];
  logic [31:0] rs2_s   [2];
  logic        flush_s [2];
  logic        hold_s  [2];
  logic        stl_s   [2];
  logic        rv_s    [2];
  logic        bsy_s   [2];
  logic [31:0] res_s   [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t cur      [2];
  int   stall_cnt[2];
  int   vrun     [2];
  logic prev_v   [2];

  always #5 clk = ~clk;

  rv32_muldiv_sequencer #(.BITS_PER_CYCLE(1)) u0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .op(op_s[0]), .rs1(rs1_s[0]), .rs2(rs2_s[0]),
    .flush(flush_s[0]), .hold(hold_s[0]), .stall_req(stl_s[0]), .result_valid(rv_s[0]),
    .result(res_s[0]), .busy(bsy_s[0]));

  rv32_muldiv_sequencer #(.BITS_PER_CYCLE(4)) u1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .op(op_s[1]), .rs1(rs1_s[1]), .rs2(rs2_s[1]),
    .flush(flush_s[1]), .hold(hold_s[1]), .stall_req(stl_s[1]), .result_valid(rv_s[1]),
    .result(res_s[1]), .busy(bsy_s[1]));

  function automatic void check(input string name, input int d, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut%0d): got 0x%08h, expected 0x%08h", name, d, act, exp);
    end
  endfunction

  // Reference: RISC-V M semantics via 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
    longint          sa, sb, prod;
    longint unsigned ua, ub, uprod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin prod = sa * sb; return prod[31:0]; end
      3'd1: begin prod = sa * sb; return prod[63:32]; end
      3'd2: begin prod = sa * longint'(ub); return prod[63:32]; end
      3'd3: begin uprod = ua * ub; return uprod[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        prod = sa / sb; return prod[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        uprod = ua / ub; return uprod[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        prod = sa % sb; return prod[31:0];
      end
      default: begin
        if (b == 0) return a;
        uprod = ua % ub; return uprod[31:0];
      end
    endcase
  endfunction

  function automatic int exp_stall(input int d, input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
    int n;
    n = (d == 0) ? 32 : 8;
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return n + 2;
  endfunction

  // Monitor: pops expectations on each new result and checks latency and hold length
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset || flush_s[d]) begin
        stall_cnt[d] = 0;
        vrun[d]      = 0;
        prev_v[d]    = 1'b0;
      end else begin
        if (stl_s[d]) stall_cnt[d]++;
        if (rv_s[d]) begin
          if (!prev_v[d]) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_valid (dut%0d): result 0x%08h, none expected", d, res_s[d]);
              cur[d].value = res_s[d];
              cur[d].stall = 0;
              cur[d].vlen  = 1;
            end else begin
              cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
              check("result", d, res_s[d], cur[d].value);
              check("stall_cycles", d, 32'(stall_cnt[d]), 32'(cur[d].stall));
            end
            stall_cnt[d] = 0;
            vrun[d]      = 1;
          end else begin
            vrun[d]++;
            check("held_result", d, res_s[d], cur[d].value);
          end
        end else if (prev_v[d]) begin
          check("valid_cycles", d, 32'(vrun[d]), 32'(cur[d].vlen));
        end
        prev_v[d] = rv_s[d];
      end
    end
  end

  task automatic issue(input int d, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int h);
    exp_t e;
    int   k;
    e.value = model(o, a, b);
    e.stall = exp_stall(d, o, a, b);
    e.vlen  = h + 1;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    start_s[d] = 1'b1;
    op_s[d]    = o;
    rs1_s[d]   = a;
    rs2_s[d]   = b;
    hold_s[d]  = (h > 0);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rv_s[d]) break;
    end
    if (k == 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout (dut%0d): no result_valid within 200 cycles for op %0d", d, o);
    end
    repeat (h) begin @(posedge clk); #1; end
    hold_s[d] = 1'b0;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_random(input int d, input int count);
    logic [2:0]  o;
    logic [31:0] a, b;
    int          h;
    for (int i = 0; i < count; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      issue(d, o, a, b, h);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; op_s[d] = '0; rs1_s[d] = '0; rs2_s[d] = '0;
      flush_s[d] = 1'b0; hold_s[d] = 1'b0;
      stall_cnt[d] = 0; vrun[d] = 0; prev_v[d] = 1'b0;
    end
    reset = 1'b1;
    start_s[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_stall_req", d, 32'(stl_s[d]), 32'h0);
      check("rst_result_valid", d, 32'(rv_s[d]), 32'h0);
      check("rst_busy", d, 32'(bsy_s[d]), 32'h0);
      check("rst_result", d, res_s[d], 32'h0);
    end
    start_s[0] = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed corner cases at 1 bit per cycle
    issue(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    issue(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(0, 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
    issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(0, 3'd5, 32'd5, 32'd0, 0);
    issue(0, 3'd7, 32'd5, 32'd0, 0);

    // Signed divide at 4 bits per cycle
    issue(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    issue(1, 3'd6, 32'hFFFF_FFF9, 32'd2, 0);

    // flush beats a simultaneous start
    start_s[0] = 1'b1; op_s[0] = 3'd5; rs1_s[0] = 32'd9; rs2_s[0] = 32'd3; flush_s[0] = 1'b1;
    #1;
    check("flush_start_stall", 0, 32'(stl_s[0]), 32'h0);
    @(posedge clk); #1;
    check("flush_start_busy", 0, 32'(bsy_s[0]), 32'h0);
    start_s[0] = 1'b0; flush_s[0] = 1'b0;

    // flush in CALC cycle 5
    start_s[0] = 1'b1; op_s[0] = 3'd5; rs1_s[0] = 32'd1000; rs2_s[0] = 32'd3;
    repeat (5) begin @(posedge clk); #1; end
    check("calc_busy", 0, 32'(bsy_s[0]), 32'h1);
    start_s[0] = 1'b0; flush_s[0] = 1'b1;
    #1;
    check("flush_stall", 0, 32'(stl_s[0]), 32'h0);
    check("flush_valid", 0, 32'(rv_s[0]), 32'h0);
    @(posedge clk); #1;
    flush_s[0] = 1'b0;
    check("flush_busy", 0, 32'(bsy_s[0]), 32'h0);
    issue(0, 3'd5, 32'd100, 32'd7, 0);

    // hold three cycles in DONE
    issue(0, 3'd0, 32'd123, 32'd456, 3);

    run_random(0, 30);
    run_random(1, 40);

    // async reset mid-CALC aborts the op
    start_s[0] = 1'b1; op_s[0] = 3'd0; rs1_s[0] = 32'd11; rs2_s[0] = 32'd13;
    repeat (3) begin @(posedge clk); #1; end
    check("calc_busy2", 0, 32'(bsy_s[0]), 32'h1);
    reset = 1'b1;
    start_s[0] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("midrst_stall_req", d, 32'(stl_s[d]), 32'h0);
      check("midrst_result_valid", d, 32'(rv_s[d]), 32'h0);
      check("midrst_busy", d, 32'(bsy_s[d]), 32'h0);
      check("midrst_result", d, res_s[d], 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    issue(0, 3'd4, 32'd100, 32'hFFFF_FFF9, 0);
    issue(1, 3'd7, 32'hFFFF_FFF9, 32'd10, 1);

    repeat (5) @(posedge clk);
    #1;
    check("q0_drained", 0, 32'(q0.size()), 32'h0);
    check("q1_drained", 1, 32'(q1.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
